// File: rtl/mul_ctrl_pkg.sv
// Shared EX-stage definitions for the multiplier sequencing controller:
// op encodings, controller state encoding and the MLU pipeline latency.
package mul_ctrl_pkg;

    // Cycles from the first edge with start high to MLU ready.
    localparam int MUL_LAT = 7;

    typedef enum logic [1:0] {
        MUL_OP_NONE  = 2'b00,
        MUL_OP_MULT  = 2'b01,   // signed, product to HI/LO
        MUL_OP_MULTU = 2'b10,   // unsigned, product to HI/LO
        MUL_OP_MUL   = 2'b11    // signed, low word to GPR
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

    // Only MULTU runs the MLU in unsigned mode.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op != MUL_OP_MULTU);
    endfunction

    // MUL writes the GPR file; MULT/MULTU write HI/LO.
    function automatic logic op_is_gpr(input logic [1:0] op);
        return (op == MUL_OP_MUL);
    endfunction

endpackage

// File: rtl/mul_ctrl.sv
// Sequencing controller for the shared multi-cycle multiplier (MLU).
// Accepts a multiply from EX, holds operands and a level-held start to the
// MLU, stalls the front end until the product is captured, then issues a
// one-cycle HI/LO or GPR writeback. Zero operands bypass the MLU entirely.
module mul_ctrl
    import mul_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid_i,
    input  logic [1:0]  ex_op_i,
    input  logic [31:0] ex_src1_i,
    input  logic [31:0] ex_src2_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        mul_start_o,
    output logic        mul_sign_o,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    input  logic        mul_ready_i,
    input  logic [63:0] mul_result_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        gpr_we_o,
    output logic [31:0] gpr_wdata_o
);

    mul_state_e  state_r;
    mul_op_e     op_r;
    logic        start_r;
    logic        sign_r;
    logic [31:0] op1_r;
    logic [31:0] op2_r;
    logic [63:0] product_r;
    logic        hilo_we_r;
    logic        gpr_we_r;

    logic        req_s;
    logic        zero_s;

    assign req_s  = ex_valid_i & (ex_op_i != MUL_OP_NONE) & ~flush_i;
    assign zero_s = (ex_src1_i == 32'd0) | (ex_src2_i == 32'd0);

    // Stall holds EX/ID/IF until the writeback cycle; a flush releases it.
    assign stall_req_o = req_s & (state_r != ST_DONE);

    assign mul_start_o = start_r;
    assign mul_sign_o  = sign_r;
    assign mul_op1_o   = op1_r;
    assign mul_op2_o   = op2_r;

    // Write-enable flags are armed on entry to DONE; a flush in DONE kills them.
    assign hilo_we_o   = hilo_we_r & ~flush_i;
    assign gpr_we_o    = gpr_we_r & ~flush_i;

    // Product halves come straight from the product register, never X.
    assign hi_o        = product_r[63:32];
    assign lo_o        = product_r[31:0];
    assign gpr_wdata_o = product_r[31:0];

    // Controller FSM with operand, product and write-enable registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            op_r      <= MUL_OP_NONE;
            start_r   <= 1'b0;
            sign_r    <= 1'b0;
            op1_r     <= 32'd0;
            op2_r     <= 32'd0;
            product_r <= 64'd0;
            hilo_we_r <= 1'b0;
            gpr_we_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    hilo_we_r <= 1'b0;
                    gpr_we_r  <= 1'b0;
                    if (req_s) begin
                        op1_r  <= ex_src1_i;
                        op2_r  <= ex_src2_i;
                        sign_r <= op_is_signed(ex_op_i);
                        op_r   <= mul_op_e'(ex_op_i);
                        if (zero_s) begin
                            // Fast path: product is known to be zero.
                            product_r <= 64'd0;
                            hilo_we_r <= ~op_is_gpr(ex_op_i);
                            gpr_we_r  <= op_is_gpr(ex_op_i);
                            state_r   <= ST_DONE;
                        end else begin
                            start_r <= 1'b1;
                            state_r <= ST_BUSY;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        // Drop the in-flight MLU result; start low restarts it.
                        start_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (mul_ready_i) begin
                        product_r <= mul_result_i;
                        start_r   <= 1'b0;
                        hilo_we_r <= ~op_is_gpr(op_r);
                        gpr_we_r  <= op_is_gpr(op_r);
                        state_r   <= ST_DONE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    // Start stays low here so the MLU sees at least one idle edge.
                    hilo_we_r <= 1'b0;
                    gpr_we_r  <= 1'b0;
                    start_r   <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    hilo_we_r <= 1'b0;
                    gpr_we_r  <= 1'b0;
                    start_r   <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
